// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_sequencer_pkg: shared widths, opcodes, FSM states, LUT contents
// Rev 1.0
// ------------------------------------------------------------------
package fetch_sequencer_pkg;

  localparam int PC_W      = 12;
  localparam int INSTR_W   = 9;
  localparam int TGT_W     = 8;
  localparam int LUT_DEPTH = 32;
  localparam int LUT_IDX_W = $clog2(LUT_DEPTH);

  localparam logic [3:0] BR_OP   = 4'b1110;
  localparam logic [3:0] HALT_OP = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FETCH = 3'd2,
    S_EXEC  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Built-in offset table image: entry i holds i*3+1.
  function automatic logic [LUT_DEPTH*TGT_W-1:0] default_lut();
    logic [LUT_DEPTH*TGT_W-1:0] img;
    img = '0;
    for (int i = 0; i < LUT_DEPTH; i++) begin
      img[i*TGT_W +: TGT_W] = TGT_W'(i * 3 + 1);
    end
    return img;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_branch_lut.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_sequencer_branch_lut: read-only branch-offset table, async read
// Rev 1.0
// ------------------------------------------------------------------
module fetch_sequencer_branch_lut
  import fetch_sequencer_pkg::*;
#(
  parameter logic [LUT_DEPTH*TGT_W-1:0] LUT_INIT = default_lut()
) (
  input  logic [LUT_IDX_W-1:0] idx,
  output logic [TGT_W-1:0]     offset
);

  logic [TGT_W-1:0] table_w [LUT_DEPTH];

  for (genvar i = 0; i < LUT_DEPTH; i++) begin : g_entry
    assign table_w[i] = LUT_INIT[i*TGT_W +: TGT_W];
  end

  assign offset = table_w[idx];

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_sequencer: fetch/decode/advance FSM for the PC and ROM.
// Define INSTR_COUNT_EN to add the retired-instruction counter. Rev 1.0
// ------------------------------------------------------------------
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [LUT_DEPTH*TGT_W-1:0] LUT_INIT = default_lut()
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    start_addr,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               branch_taken,
  input  logic               exec_stall,
  output logic               pc_start,
  output logic               next_ins,
  output logic               jump_flag,
  output logic [TGT_W-1:0]   target,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  output logic               busy,
  output logic               done
`ifdef INSTR_COUNT_EN
  ,
  output logic [15:0]        instr_count
`endif
);

  state_t           state;
  state_t           state_next;
  logic             is_branch;
  logic             is_halt;
  logic [TGT_W-1:0] lut_offset;

  fetch_sequencer_branch_lut #(
    .LUT_INIT (LUT_INIT)
  ) u_branch_lut (
    .idx    (instr[LUT_IDX_W-1:0]),
    .offset (lut_offset)
  );

  assign is_branch = (instr[INSTR_W-1 -: 4] == BR_OP);
  assign is_halt   = (instr[INSTR_W-1 -: 4] == HALT_OP);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_start   = 1'b0;
    next_ins   = 1'b0;
    jump_flag  = 1'b0;
    target     = '0;
    imem_en    = 1'b0;
    imem_addr  = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: ;
      S_LOAD: begin
        pc_start   = 1'b1;
        busy       = 1'b1;
        state_next = S_FETCH;
      end
      S_FETCH: begin
        imem_en    = 1'b1;
        imem_addr  = pc;
        busy       = 1'b1;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        busy = 1'b1;
        // A restart request drops the in-flight instruction without advancing.
        if (!exec_stall && !start) begin
          if (is_halt) begin
            state_next = S_DONE;
          end else begin
            next_ins   = 1'b1;
            state_next = S_FETCH;
            if (is_branch) begin
              target    = lut_offset;
              jump_flag = branch_taken;
            end
          end
        end
      end
      S_DONE: done = 1'b1;
      default: state_next = S_IDLE;
    endcase
    if (start) begin
      state_next = S_LOAD;
    end
  end

`ifdef INSTR_COUNT_EN
  logic        retire;
  logic [15:0] count_r;

  // Every non-stalled, non-restarted EXEC retires one instruction, halt included.
  assign retire = (state == S_EXEC) && !exec_stall && !start;

  always_ff @(posedge clock) begin
    if (reset || state == S_LOAD) begin
      count_r <= '0;
    end else if (retire && count_r != 16'hFFFF) begin
      count_r <= count_r + 16'd1;
    end
  end

  assign instr_count = count_r;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_fetch_sequencer: random + directed programs against a walk model
// Rev 1.0
// ------------------------------------------------------------------
module tb_fetch_sequencer;

  typedef struct packed {
    logic       jump;
    logic [7:0] tgt;
  } adv_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [11:0] start_addr;
  logic [11:0] pc;
  logic [8:0]  instr;
  logic        branch_taken;
  logic        exec_stall;
  logic        pc_start;
  logic        next_ins;
  logic        jump_flag;
  logic [7:0]  target;
  logic        imem_en;
  logic [11:0] imem_addr;
  logic        busy;
  logic        done;
`ifdef INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  fetch_sequencer dut (
    .clock        (clk),
    .reset        (reset),
    .start        (start),
    .start_addr   (start_addr),
    .pc           (pc),
    .instr        (instr),
    .branch_taken (branch_taken),
    .exec_stall   (exec_stall),
    .pc_start     (pc_start),
    .next_ins     (next_ins),
    .jump_flag    (jump_flag),
    .target       (target),
    .imem_en      (imem_en),
    .imem_addr    (imem_addr),
    .busy         (busy),
    .done         (done)
`ifdef INSTR_COUNT_EN
    ,
    .instr_count  (instr_count)
`endif
  );

  logic [8:0] rom [4096];
  bit         taken_map [4096];
  logic [11:0] fetch_q [$];
  adv_t        adv_q [$];
  logic [11:0] exp_final;
  int          exp_adv, exp_count;
  int          checks = 0, errors = 0;
  int          cyc = 0, fetch_cyc = 0, last_adv_cyc = 0, stalled = 0;
  int          adv_cnt = 0, pc_start_cnt = 0, done_cnt = 0;
  int          stall_mode = 0, stall_left = 0;
  bit          adv_pending = 0, prev_done = 0, fetch_last = 0;
  adv_t        e;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Program counter and registered ROM around the sequencer.
  always @(posedge clk) begin
    if (pc_start) pc <= start_addr;
    else if (next_ins) pc <= pc + 12'd1 + (jump_flag ? {4'b0, target} : 12'd0);
    if (imem_en) instr <= rom[imem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lut_ref(input logic [4:0] i);
    return 8'(i * 3 + 1);
  endfunction

  function automatic logic [25:0] outs();
    return {pc_start, next_ins, jump_flag, target, imem_en, imem_addr, busy, done};
  endfunction

  // Walk the program as the spec defines it; forcing a halt after 20 steps keeps runs short.
  task automatic model_run(input logic [11:0] sa);
    logic [11:0] a;
    logic [8:0]  ins;
    logic        tk, br, halted;
    logic [7:0]  tg;
    a = sa; halted = 0;
    fetch_q.delete(); adv_q.delete();
    exp_adv = 0; exp_count = 0; adv_cnt = 0; pc_start_cnt = 0;
    for (int n = 0; n < 20 && !halted; n++) begin
      if (n == 19) rom[a][8:5] = 4'hF;
      ins = rom[a];
      fetch_q.push_back(a);
      exp_count++;
      if (ins[8:5] == 4'hF) begin
        exp_final = a;
        halted = 1;
      end else begin
        br = (ins[8:5] == 4'hE);
        tk = br && taken_map[a];
        tg = br ? lut_ref(ins[4:0]) : 8'd0;
        adv_q.push_back('{jump: tk, tgt: tg});
        exp_adv++;
        a = a + 12'd1 + (tk ? {4'b0, tg} : 12'd0);
      end
    end
  endtask

  // Input drivers: stall pattern and branch flag for the instruction at pc.
  initial begin
    exec_stall = 0; branch_taken = 0;
    forever begin
      @(posedge clk); #2;
      case (stall_mode)
        1: exec_stall = ($urandom_range(0, 2) == 0);
        2: begin
          if (fetch_last) stall_left = 3;
          exec_stall = (stall_left > 0);
          if (stall_left > 0) stall_left--;
        end
        3: exec_stall = 1;
        default: exec_stall = 0;
      endcase
      branch_taken = taken_map[pc];
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      fetch_last = imem_en;
      if (pc_start) pc_start_cnt++;
      if (busy && !imem_en && !pc_start && exec_stall) stalled++;
      if (jump_flag && !next_ins) chk("jump_without_advance", 1, 0);
      if (next_ins) begin
        chk("advance_during_stall", {31'b0, exec_stall}, 0);
        chk("exec_latency", cyc - fetch_cyc, 1 + stalled);
        adv_cnt++;
        if (adv_q.size() == 0) chk("advance_unexpected", 1, 0);
        else begin
          e = adv_q.pop_front();
          chk("jump_flag", {31'b0, jump_flag}, {31'b0, e.jump});
          chk("target", {24'b0, target}, {24'b0, e.tgt});
        end
        adv_pending = 1; last_adv_cyc = cyc;
      end
      if (imem_en) begin
        if (adv_pending) chk("fetch_after_advance", cyc - last_adv_cyc, 1);
        adv_pending = 0; fetch_cyc = cyc; stalled = 0;
        if (fetch_q.size() == 0) chk("fetch_unexpected", 1, 0);
        else chk("fetch_addr", {20'b0, imem_addr}, {20'b0, fetch_q.pop_front()});
      end
      if (done && !prev_done) begin
        chk("final_pc", {20'b0, pc}, {20'b0, exp_final});
        chk("done_not_busy", {31'b0, busy}, 0);
        done_cnt++;
      end
      prev_done = done;
    end
  end

  task automatic finish_program(input int d0);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 2000) begin
      @(posedge clk); t++;
    end
    if (done_cnt == d0) chk("done_timeout", 0, 1);
    chk("fetch_q_drained", fetch_q.size(), 0);
    chk("adv_q_drained", adv_q.size(), 0);
    chk("pc_start_once", pc_start_cnt, 1);
    chk("advance_count", adv_cnt, exp_adv);
`ifdef INSTR_COUNT_EN
    chk("instr_count", {16'b0, instr_count}, exp_count);
`endif
  endtask

  task automatic run_program(input logic [11:0] sa, input int smode);
    int d0;
    d0 = done_cnt;
    @(posedge clk); #2;
    stall_mode = smode;
    model_run(sa);
    start = 1; start_addr = sa;
    @(posedge clk); #2;
    start = 0;
    finish_program(d0);
  endtask

  task automatic launch_and_wait_fetch(input logic [11:0] sa);
    bit seen;
    @(posedge clk); #2;
    stall_mode = 0;
    model_run(sa);
    start = 1; start_addr = sa;
    @(posedge clk); #2;
    start = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = imem_en;
    end
    if (!seen) chk("first_fetch_timeout", 0, 1);
  endtask

  task automatic restart_test();
    int d0;
    rom[12'h200] = 9'h012; rom[12'h201] = 9'h012; rom[12'h202] = 9'h1E0;
    rom[12'h100] = 9'h012; rom[12'h101] = 9'h1E0;
    d0 = done_cnt;
    launch_and_wait_fetch(12'h200);
    @(posedge clk); #2;
    start = 1; start_addr = 12'h100;
    model_run(12'h100);
    @(negedge clk);
    chk("restart_no_advance", {31'b0, next_ins}, 0);
    @(posedge clk); #2;
    start = 0;
    @(negedge clk);
    chk("restart_load", {31'b0, pc_start}, 1);
    finish_program(d0);
  endtask

  task automatic reset_test();
    rom[12'h300] = 9'h012; rom[12'h301] = 9'h012; rom[12'h302] = 9'h1E0;
    launch_and_wait_fetch(12'h300);
    stall_mode = 3;
    @(posedge clk); #2;
    reset = 1;
    @(posedge clk); #2;
    reset = 0; stall_mode = 0;
    @(negedge clk);
    chk("reset_midexec_idle", {6'b0, outs()}, 0);
    repeat (3) @(negedge clk);
    chk("idle_hold", {6'b0, outs()}, 0);
    chk("no_pc_strobe_after_reset", {20'b0, pc}, 32'h300);
`ifdef INSTR_COUNT_EN
    chk("instr_count_reset", {16'b0, instr_count}, 0);
`endif
    fetch_q.delete(); adv_q.delete();
  endtask

  initial begin
    reset = 1; start = 0; start_addr = '0; pc = '0; instr = '0;
    for (int i = 0; i < 4096; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 12)      rom[i] = {4'hE, 5'($urandom)};
      else if (r < 17) rom[i] = {4'hF, 5'($urandom)};
      else             rom[i] = {4'($urandom_range(0, 13)), 5'($urandom)};
      taken_map[i] = 1'($urandom);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {6'b0, outs()}, 0);
    @(posedge clk); #2;
    reset = 0;

    // Three plain ops then halt.
    rom[12'h010] = 9'h012; rom[12'h011] = 9'h013; rom[12'h012] = 9'h014; rom[12'h013] = 9'h1E0;
    run_program(12'h010, 0);

    // Branch at 0x020 via lut[5], taken then not taken.
    rom[12'h020] = {4'hE, 5'd5}; rom[12'h031] = 9'h1E0; rom[12'h021] = 9'h1E0;
    taken_map[12'h020] = 1;
    run_program(12'h020, 0);
    taken_map[12'h020] = 0;
    run_program(12'h020, 0);

    // Three stall cycles on each EXEC.
    rom[12'h005] = 9'h012; rom[12'h006] = 9'h1E0;
    run_program(12'h005, 2);

    // Halt outranks a raised branch flag.
    rom[12'h400] = 9'h012; rom[12'h401] = {4'hF, 5'd7};
    taken_map[12'h401] = 1;
    run_program(12'h400, 0);

    restart_test();
    reset_test();

    for (int k = 0; k < 15; k++) begin
      run_program(12'($urandom_range(0, 12'h7FF)), (k % 4 == 0) ? 0 : 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control end of the program-counter interface: produces the PC's start / next-instruction / jump / target controls and consumes the PC value.
- Fetches each instruction from the registered instruction ROM and classifies it as branch, halt or plain.
- Steps the program counter one instruction at a time until a halt instruction retires.
- Sits between the top-level start/done handshake, the program counter, the instruction ROM and the ALU flag output.

Parameters:
PC_W, 12, program-counter / ROM address width
INSTR_W, 9, instruction width
TGT_W, 8, branch target-offset width
BR_OP, 4'b1110, value of instr[8:5] marking a branch
HALT_OP, 4'b1111, value of instr[8:5] marking halt
LUT_DEPTH, 32, branch-offset LUT entries (indexed by instr[4:0])

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
start  in  1  pulse: begin program at start_addr
start_addr  in  PC_W  program entry address
pc  in  PC_W  current program-counter value
instr  in  INSTR_W  ROM read data, valid the cycle after imem_en
branch_taken  in  1  ALU condition flag, sampled in EXEC
exec_stall  in  1  datapath busy (multi-cycle op); hold in EXEC
pc_start  out  1  load start_addr into PC
next_ins  out  1  advance PC this edge
jump_flag  out  1  with next_ins: PC <= pc+1+target
target  out  TGT_W  branch offset, valid when jump_flag=1
imem_en  out  1  ROM read enable
imem_addr  out  PC_W  ROM address (= pc)
busy  out  1  high in LOAD/FETCH/EXEC
done  out  1  high in DONE

Behaviour:
- Reset: state=IDLE; all outputs 0; ROM output register ignored.
- IDLE: all outputs 0. start=1 -> LOAD.
- LOAD (1 cycle): pc_start=1, busy=1 -> FETCH.
- FETCH (1 cycle): imem_en=1, imem_addr=pc -> EXEC.
- EXEC: decode instr.
  - exec_stall=1: stay in EXEC; next_ins=0, jump_flag=0.
  - Else instr[8:5]==HALT_OP: next_ins=0 -> DONE.
  - Else: next_ins=1; jump_flag = (instr[8:5]==BR_OP) & branch_taken; target = lut[instr[4:0]] when branch, else 0 -> FETCH.
- Latency: a non-stalled instruction takes exactly 2 cycles (FETCH+EXEC). The PC updates on the edge that leaves EXEC; FETCH sees the new pc.
- DONE: done=1, busy=0; held until start=1 -> LOAD. done clears on the cycle LOAD is entered.
- start while busy: restart. Next state is LOAD regardless of current state; the in-flight instruction is dropped with no next_ins that cycle.
- reset mid-operation: IDLE next cycle, no further PC strobes.
- Halt has priority over branch_taken; a branch not taken is a plain advance (jump_flag=0).
- pc/target arithmetic lives in the PC: target is unsigned, zero-extended, and the sum wraps mod 2^PC_W. This block performs no range check and does no special handling at pc=4095.
- Outputs next_ins/jump_flag/target/pc_start/imem_en are combinational from state plus instr; state is registered.

Optional Feature:
INSTR_COUNT_EN
- Defined: adds output instr_count[15:0].
  - Cleared on reset and in LOAD.
  - Increments on each EXEC cycle with next_ins=1, plus 1 for the halt instruction; saturates at 16'hFFFF.
  - Holds value in DONE.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: state enum (IDLE, LOAD, FETCH, EXEC, DONE), opcode constants BR_OP/HALT_OP, width constants PC_W/INSTR_W/TGT_W.
- Sub-module branch_lut: LUT_DEPTH x TGT_W read-only table, combinational read on instr[4:0], contents from an init file.
- The sequencer holds the FSM and decode only.

Test Plan:
- Reset then start, start_addr=0x010, ROM of three plain ops then halt -> pc_start for 1 cycle; next_ins pulses exactly 3 times, 2 cycles apart; done=1 with pc=0x013.
- Branch at 0x020, lut[5]=8'h10, branch_taken=1 -> jump_flag=1, target=0x10, next fetch at 0x031. Same case with branch_taken=0 -> jump_flag=0, next fetch at 0x021.
- exec_stall high 3 cycles on instr at 0x005 -> next_ins held 0 for 3 cycles, then one pulse; no duplicate advance.
- start pulsed while in EXEC, start_addr=0x100 -> next cycle is LOAD, no next_ins on that edge, then fetch from 0x100.
- reset asserted mid-EXEC -> next cycle all outputs 0 in IDLE; halt-with-branch_taken=1 -> DONE with jump_flag=0. With INSTR_COUNT_EN, a 4-instruction program ends with instr_count=4.
